kalman_scalar_mc: RTL and testbench
===================================

Name: kalman_scalar_mc

Overview:
Parametrised multi-channel scalar Kalman filter (linear, 1-state per channel), time-multiplexing one Q-format multiplier and one sequential divider across CH channels. Generalises the motor EKF datapath to arbitrary N/Q widths and channel count. Adds a valid/ready handshake, per-channel state memory and status flags. Intended for per-phase current and sensor smoothing ahead of the EKF.

Parameters:
N, 32, signed fixed-point word width
Q, 18, fractional bits (sf = 2^Q)
CH, 4, number of channels
CH_W, 2, channel index width (CH <= 2^CH_W)
A_COEF, 2^Q, state transition coefficient (Q-format)
P_INIT, 5*2^Q, covariance value after reset or init
GATE_TH, 2*2^Q, innovation gate threshold (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  sample valid
in_ready  out  1  high only in IDLE
in_ch  in  CH_W  channel index
in_z  in  N  measurement (Q-format, signed)
in_init  in  1  reinitialise channel: x=in_z, p=P_INIT
q_noise  in  N  process noise, sampled at accept
r_noise  in  N  measurement noise, sampled at accept
out_valid  out  1  one-cycle result pulse
out_ch  out  CH_W  channel of result
out_x  out  N  updated state
out_p  out  N  updated covariance
out_k  out  N  gain used
out_rej  out  1  update skipped by gate (0 without feature)
status  out  3  sticky: [0] mult saturation, [1] invalid denominator, [2] bad channel
clr_status  in  1  synchronous clear of status

Behaviour:
- Reset: state=IDLE; all outputs 0; in_ready=1 after release; every channel x=0, p=P_INIT. Channel memory is a register array so it can be reset.
- Accept: in_valid && in_ready at a rising edge. Capture ch, z, init, q, r.
- States: IDLE -> PX -> PP1 -> PP2 -> DIV -> UX -> UP -> WB -> IDLE.
- PX computes x_p = A*x.
- PP1 computes t = A*p.
- PP2 computes p_p = A*t + q.
- DIV takes Q+1 cycles: d = p_p + r; K = floor(p_p*2^Q/d), restoring divider, 1 bit/cycle.
- UX computes x' = x_p + K*(z - x_p).
- UP computes p' = (sf - K)*p_p.
- WB writes x', p' to memory, drives out_* and pulses out_valid, then returns to IDLE.
- Latency: out_valid high Q+7 cycles after the accept edge (25 at Q=18). in_ready returns high in the same cycle as out_valid.
- Init path: IDLE -> WB. Writes x=z, p=P_INIT, out_k=0. out_valid 1 cycle after accept.
- Multiply: full 2N product, arithmetic shift right by Q (floor), saturate to the signed N range. Saturation sets status[0]. Adds and subtracts also saturate.
- Denominator d <= 0: K=0, set status[1]. Result is x'=x_p, p'=p_p.
- K is clamped to at most sf.
- p' < 0 is clamped to 0. p_p < 0 is treated as 0 before division.
- in_ch >= CH: sample accepted and dropped. No out_valid. Set status[2]. Back to IDLE next cycle.
- clr_status and a flag set in the same cycle: the set wins.
- Reset asserted mid-operation: immediate abort to IDLE. All channel memory is reinitialised. No out_valid.
- out_* hold their last values between pulses.

Optional Feature:
Macro KALMAN_INNOV_GATE_EN.
- Defined: in UX, if |z - x_p| > GATE_TH, skip the update. Result is x'=x_p, p'=p_p, out_k=0, out_rej=1. Latency is unchanged.
- Undefined: out_rej is tied to 0 and no comparator is built.

Test Plan:
1. Reset; accept ch0, z=262144, q=0, r=262144 -> out_valid exactly 25 cycles later with out_x=218453, out_k=218453, out_p=218455, out_ch=0.
2. Init ch1 with z=786432 -> out_valid 1 cycle after accept with out_x=786432, out_p=1310720, out_k=0. A following normal sample on ch1 uses x=786432.
3. Interleave: ch0 sample from test 1, then ch2 with the same stimulus -> ch2 result identical to test 1. A second ch0 sample uses x=218453, p=218455.
4. Bench instance CH=3: in_ch=3 -> no out_valid, status=3'b100, in_ready high 1 cycle later. clr_status -> status=0.
5. Accept ch0 with z=262144, q=0, r=-6*262144 (d=-262144) -> out_k=0, out_x=0, out_p=1310720, status[1]=1.
6. Assert reset during DIV -> in_ready=1 and out_valid=0 after release. Repeating test 1 gives identical values. With the gate feature enabled, z=3*262144 on a fresh channel -> out_rej=1, out_x=0, out_p=1310720.

Source files
------------

// File: rtl/kalman_scalar_mc_if.sv
// Sample/result handshake bundle for the multi-channel scalar Kalman filter.
// The master drives samples and status clear; the slave returns results and flags.
interface kalman_scalar_mc_if #(
  parameter int N    = 32,
  parameter int CH_W = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CH_W-1:0]        in_ch;
  logic signed [N-1:0]    in_z;
  logic                   in_init;
  logic signed [N-1:0]    q_noise;
  logic signed [N-1:0]    r_noise;
  logic                   out_valid;
  logic [CH_W-1:0]        out_ch;
  logic signed [N-1:0]    out_x;
  logic signed [N-1:0]    out_p;
  logic signed [N-1:0]    out_k;
  logic                   out_rej;
  logic [2:0]             status;
  logic                   clr_status;

  modport slave (
    input  in_valid, in_ch, in_z, in_init, q_noise, r_noise, clr_status,
    output in_ready, out_valid, out_ch, out_x, out_p, out_k, out_rej, status
  );

  modport master (
    output in_valid, in_ch, in_z, in_init, q_noise, r_noise, clr_status,
    input  in_ready, out_valid, out_ch, out_x, out_p, out_k, out_rej, status
  );
endinterface

// File: rtl/kalman_scalar_mc.sv
// Multi-channel 1-state Kalman filter sharing one Q-format multiplier and one restoring divider.
// Optional innovation gate enabled by defining KALMAN_INNOV_GATE_EN.
module kalman_scalar_mc #(
  parameter int N    = 32,
  parameter int Q    = 18,
  parameter int CH   = 4,
  parameter int CH_W = 2,
  parameter logic signed [N-1:0] A_COEF = N'(64'sd1 <<< Q),
  parameter logic signed [N-1:0] P_INIT = N'(64'sd5 <<< Q)
`ifdef KALMAN_INNOV_GATE_EN
  ,
  parameter logic signed [N-1:0] GATE_TH = N'(64'sd2 <<< Q)
`endif
) (
  input  logic               clk,
  input  logic               reset,
  kalman_scalar_mc_if.slave  bus
);

  localparam logic signed [N-1:0] SF   = N'(64'sd1 <<< Q);
  localparam logic signed [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam int CW = $clog2(Q + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PX, S_PP1, S_PP2, S_DIV, S_UX, S_UP, S_WB} state_t;

  // Result word is {overflow flag, saturated value}.
  function automatic logic [N:0] sat_mul(input logic signed [N-1:0] a,
                                         input logic signed [N-1:0] b);
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] sh;
    prod = (2*N)'(a) * (2*N)'(b);
    sh   = prod >>> Q;
    if (sh > (2*N)'(MAXV))      return {1'b1, MAXV};
    else if (sh < (2*N)'(MINV)) return {1'b1, MINV};
    else                        return {1'b0, sh[N-1:0]};
  endfunction

  function automatic logic [N:0] sat_add(input logic signed [N-1:0] a,
                                         input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = (N+1)'(a) + (N+1)'(b);
    if (s > (N+1)'(MAXV))      return {1'b1, MAXV};
    else if (s < (N+1)'(MINV)) return {1'b1, MINV};
    else                       return {1'b0, s[N-1:0]};
  endfunction

  function automatic logic [N:0] sat_sub(input logic signed [N-1:0] a,
                                         input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = (N+1)'(a) - (N+1)'(b);
    if (s > (N+1)'(MAXV))      return {1'b1, MAXV};
    else if (s < (N+1)'(MINV)) return {1'b1, MINV};
    else                       return {1'b0, s[N-1:0]};
  endfunction

  state_t state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          status_q;
  logic signed [N-1:0] x_mem_q [CH];
  logic signed [N-1:0] p_mem_q [CH];
  logic                out_valid_q, out_rej_q;
  logic [CH_W-1:0]     out_ch_q;
  logic signed [N-1:0] out_x_q, out_p_q, out_k_q;

  logic [CH_W-1:0]     ch_q;
  logic                init_q, drop_q, big_q, bad_q, rej_q;
  logic signed [N-1:0] z_q, q_q, r_q, xp_q, t_q, pp_q, k_q, xn_q, pn_q;
  logic [N-1:0]        den_q;
  logic [N+1:0]        rem_q;
  logic [Q:0]          quo_q;

  logic accept, ch_bad, gate_hit, set_sat, set_div, set_ch;
  logic signed [N-1:0] x_cur, p_cur, mul_a, mul_b, mul_y;
  logic signed [N-1:0] pp_next, pp_pos, d_val, innov, ux_sum, k_fin, wb_x, wb_p, wb_k;
  logic [N:0]          mul_r, pp_r, d_r, innov_r, ux_r;
  logic [N+1:0]        den_ext, rem_sh, rem_nx;
  logic [Q:0]          quo_nx;
  logic                div_ge;

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign accept        = bus.in_valid && bus.in_ready;
  assign ch_bad        = (32'(bus.in_ch) >= CH);
  assign x_cur         = x_mem_q[ch_q];
  assign p_cur         = p_mem_q[ch_q];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_PX:    begin mul_a = A_COEF;    mul_b = x_cur; end
      S_PP1:   begin mul_a = A_COEF;    mul_b = p_cur; end
      S_PP2:   begin mul_a = A_COEF;    mul_b = t_q;   end
      S_UX:    begin mul_a = k_q;       mul_b = innov; end
      S_UP:    begin mul_a = SF - k_q;  mul_b = pp_q;  end
      default: ;
    endcase
  end

  assign mul_r   = sat_mul(mul_a, mul_b);
  assign mul_y   = $signed(mul_r[N-1:0]);
  assign pp_r    = sat_add(mul_y, q_q);
  assign pp_next = $signed(pp_r[N-1:0]);
  assign pp_pos  = (pp_next < 0) ? '0 : pp_next;
  assign d_r     = sat_add(pp_pos, r_q);
  assign d_val   = $signed(d_r[N-1:0]);
  assign innov_r = sat_sub(z_q, xp_q);
  assign innov   = $signed(innov_r[N-1:0]);
  assign ux_r    = sat_add(xp_q, mul_y);
  assign ux_sum  = $signed(ux_r[N-1:0]);

  // First divider step weighs the 2^Q quotient bit without shifting the remainder.
  assign den_ext = {2'b00, den_q};
  assign rem_sh  = (cnt_q == '0) ? rem_q : {rem_q[N:0], 1'b0};
  assign div_ge  = (rem_sh >= den_ext);
  assign rem_nx  = div_ge ? (rem_sh - den_ext) : rem_sh;
  assign quo_nx  = {quo_q[Q-1:0], div_ge};
  assign k_fin   = bad_q ? '0 : (big_q ? SF : $signed({{(N-Q-1){1'b0}}, quo_nx}));

`ifdef KALMAN_INNOV_GATE_EN
  logic signed [N:0] innov_wide, innov_abs;
  assign innov_wide = (N+1)'(innov);
  assign innov_abs  = (innov_wide < 0) ? -innov_wide : innov_wide;
  assign gate_hit   = (innov_abs > (N+1)'(GATE_TH));
`else
  assign gate_hit = 1'b0;
`endif

  always_comb begin
    set_sat = 1'b0;
    case (state_q)
      S_PX, S_PP1, S_UP: set_sat = mul_r[N];
      S_PP2:             set_sat = mul_r[N] | pp_r[N] | d_r[N];
      S_UX:              set_sat = mul_r[N] | innov_r[N] | ux_r[N];
      default: ;
    endcase
  end
  assign set_div = (state_q == S_PP2) && (d_val <= 0);
  assign set_ch  = accept && ch_bad;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (ch_bad || bus.in_init) ? S_WB : S_PX;
      S_PX:    state_d = S_PP1;
      S_PP1:   state_d = S_PP2;
      S_PP2:   state_d = S_DIV;
      S_DIV:   if (cnt_q == CW'(Q)) state_d = S_UX;
      S_UX:    state_d = S_UP;
      S_UP:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wb_x = init_q ? z_q    : xn_q;
  assign wb_p = init_q ? P_INIT : pn_q;
  assign wb_k = init_q ? '0     : k_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_x_q     <= '0;
      out_p_q     <= '0;
      out_k_q     <= '0;
      out_rej_q   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        x_mem_q[i] <= '0;
        p_mem_q[i] <= P_INIT;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      status_q    <= (bus.clr_status ? 3'b000 : status_q) | {set_ch, set_div, set_sat};
      if (state_q == S_PP2)      cnt_q <= '0;
      else if (state_q == S_DIV) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_WB && !drop_q) begin
        x_mem_q[ch_q] <= wb_x;
        p_mem_q[ch_q] <= wb_p;
        out_valid_q   <= 1'b1;
        out_ch_q      <= ch_q;
        out_x_q       <= wb_x;
        out_p_q       <= wb_p;
        out_k_q       <= wb_k;
        out_rej_q     <= init_q ? 1'b0 : rej_q;
      end
    end
  end

  // Datapath registers carry no reset; the FSM guarantees they are written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      ch_q   <= bus.in_ch;
      z_q    <= bus.in_z;
      init_q <= bus.in_init;
      drop_q <= ch_bad;
      q_q    <= bus.q_noise;
      r_q    <= bus.r_noise;
      rej_q  <= 1'b0;
    end
    case (state_q)
      S_PX:  xp_q <= mul_y;
      S_PP1: t_q  <= mul_y;
      S_PP2: begin
        pp_q  <= pp_next;
        den_q <= d_val[N-1:0];
        rem_q <= {2'b00, pp_pos};
        quo_q <= '0;
        big_q <= (pp_pos >= d_val);
        bad_q <= (d_val <= 0);
      end
      S_DIV: begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        if (cnt_q == CW'(Q)) k_q <= k_fin;
      end
      S_UX: begin
        if (gate_hit) begin
          xn_q  <= xp_q;
          k_q   <= '0;
          rej_q <= 1'b1;
        end else begin
          xn_q  <= ux_sum;
        end
      end
      S_UP:  pn_q <= (mul_y < 0) ? '0 : mul_y;
      default: ;
    endcase
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_k     = out_k_q;
  assign bus.out_rej   = out_rej_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_kalman_scalar_mc.sv
// Directed self-checking bench for kalman_scalar_mc (3-channel instance, Q=18).
module tb_kalman_scalar_mc;
  localparam int N = 32, Q = 18, CH = 3, CH_W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kalman_scalar_mc_if #(.N(N), .CH_W(CH_W)) bus ();
  kalman_scalar_mc #(.N(N), .Q(Q), .CH(CH), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_z = '0; bus.in_init = 1'b0;
    bus.q_noise = '0; bus.r_noise = '0; bus.clr_status = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic accept_sample(input logic [CH_W-1:0] ch, input logic signed [N-1:0] z,
                               input logic init, input logic signed [N-1:0] q,
                               input logic signed [N-1:0] r);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready: in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_ch = ch; bus.in_z = z; bus.in_init = init;
    bus.q_noise = q; bus.r_noise = r;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_init = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_x !== 0 || bus.out_p !== 0 || bus.out_k !== 0) begin
      failures++; $display("FAIL reset_outputs: valid=%b x=%0d p=%0d k=%0d expected all 0", bus.out_valid, bus.out_x, bus.out_p, bus.out_k); end
    checks++; if (bus.status !== 3'b000) begin failures++; $display("FAIL reset_status: got %b expected 000", bus.status); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_release: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic(input string tag);
    int lat;
    accept_sample(2'd0, 262144, 1'b0, 0, 262144);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL %s_busy: in_ready=%b expected 0", tag, bus.in_ready); end
    wait_out(lat);
    checks++; if (lat != 25) begin failures++; $display("FAIL %s_latency: got %0d expected 25", tag, lat); end
    checks++; if (bus.out_x !== 218453) begin failures++; $display("FAIL %s_x: got %0d expected 218453", tag, bus.out_x); end
    checks++; if (bus.out_k !== 218453) begin failures++; $display("FAIL %s_k: got %0d expected 218453", tag, bus.out_k); end
    checks++; if (bus.out_p !== 218455) begin failures++; $display("FAIL %s_p: got %0d expected 218455", tag, bus.out_p); end
    checks++; if (bus.out_ch !== 2'd0 || bus.out_rej !== 1'b0) begin failures++; $display("FAIL %s_ch_rej: ch=%0d rej=%b expected 0 0", tag, bus.out_ch, bus.out_rej); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_with_valid: got %b expected 1", tag, bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_x !== 218453) begin
      failures++; $display("FAIL %s_pulse_hold: valid=%b x=%0d expected 0 218453", tag, bus.out_valid, bus.out_x); end
  endtask

  task automatic test_init();
    int lat;
    accept_sample(2'd1, 786432, 1'b1, 0, 0);
    wait_out(lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL init_latency: got %0d expected 1", lat); end
    checks++; if (bus.out_x !== 786432 || bus.out_p !== 1310720 || bus.out_k !== 0 || bus.out_ch !== 2'd1) begin
      failures++; $display("FAIL init_values: x=%0d p=%0d k=%0d ch=%0d expected 786432 1310720 0 1", bus.out_x, bus.out_p, bus.out_k, bus.out_ch); end
    accept_sample(2'd1, 786432, 1'b0, 0, 262144);
    wait_out(lat);
    checks++; if (lat != 25) begin failures++; $display("FAIL init_follow_latency: got %0d expected 25", lat); end
    checks++; if (bus.out_x !== 786432 || bus.out_p !== 218455 || bus.out_k !== 218453) begin
      failures++; $display("FAIL init_follow_values: x=%0d p=%0d k=%0d expected 786432 218455 218453", bus.out_x, bus.out_p, bus.out_k); end
  endtask

  task automatic test_interleave();
    int lat;
    accept_sample(2'd2, 262144, 1'b0, 0, 262144);
    wait_out(lat);
    checks++; if (lat != 25 || bus.out_ch !== 2'd2) begin failures++; $display("FAIL ch2_lat_ch: lat=%0d ch=%0d expected 25 2", lat, bus.out_ch); end
    checks++; if (bus.out_x !== 218453 || bus.out_p !== 218455 || bus.out_k !== 218453) begin
      failures++; $display("FAIL ch2_values: x=%0d p=%0d k=%0d expected 218453 218455 218453", bus.out_x, bus.out_p, bus.out_k); end
    accept_sample(2'd0, 262144, 1'b0, 0, 262144);
    wait_out(lat);
    checks++; if (lat != 25 || bus.out_ch !== 2'd0) begin failures++; $display("FAIL ch0_second_lat_ch: lat=%0d ch=%0d expected 25 0", lat, bus.out_ch); end
    checks++; if (bus.out_x !== 238312 || bus.out_p !== 119157 || bus.out_k !== 119156) begin
      failures++; $display("FAIL ch0_second_values: x=%0d p=%0d k=%0d expected 238312 119157 119156", bus.out_x, bus.out_p, bus.out_k); end
  endtask

  task automatic test_bad_channel();
    int seen = 0;
    accept_sample(2'd3, 262144, 1'b0, 0, 262144);
    if (bus.out_valid) seen++;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL badch_ready: got %b expected 1", bus.in_ready); end
    if (bus.out_valid) seen++;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL badch_no_output: pulses=%0d expected 0", seen); end
    checks++; if (bus.status !== 3'b100) begin failures++; $display("FAIL badch_status: got %b expected 100", bus.status); end
    @(negedge clk); bus.clr_status = 1'b1;
    @(negedge clk); bus.clr_status = 1'b0;
    checks++; if (bus.status !== 3'b000) begin failures++; $display("FAIL clr_status: got %b expected 000", bus.status); end
  endtask

  task automatic test_bad_denominator();
    int lat;
    apply_reset();
    accept_sample(2'd0, 262144, 1'b0, 0, -1572864);
    wait_out(lat);
    checks++; if (lat != 25) begin failures++; $display("FAIL baddiv_latency: got %0d expected 25", lat); end
    checks++; if (bus.out_k !== 0 || bus.out_x !== 0 || bus.out_p !== 1310720) begin
      failures++; $display("FAIL baddiv_values: k=%0d x=%0d p=%0d expected 0 0 1310720", bus.out_k, bus.out_x, bus.out_p); end
    checks++; if (bus.status !== 3'b010) begin failures++; $display("FAIL baddiv_status: got %b expected 010", bus.status); end
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    accept_sample(2'd0, 262144, 1'b0, 0, 262144);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_during_reset: ready=%b valid=%b expected 0 0", bus.in_ready, bus.out_valid); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.status !== 3'b000) begin
      failures++; $display("FAIL abort_release: ready=%b status=%b expected 1 000", bus.in_ready, bus.status); end
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_output: pulses=%0d expected 0", seen); end
    test_basic("after_abort");
  endtask

  task automatic test_gate();
`ifdef KALMAN_INNOV_GATE_EN
    int lat;
    accept_sample(2'd1, 786432, 1'b0, 0, 262144);
    wait_out(lat);
    checks++; if (lat != 25) begin failures++; $display("FAIL gate_latency: got %0d expected 25", lat); end
    checks++; if (bus.out_rej !== 1'b1 || bus.out_x !== 0 || bus.out_p !== 1310720 || bus.out_k !== 0) begin
      failures++; $display("FAIL gate_values: rej=%b x=%0d p=%0d k=%0d expected 1 0 1310720 0", bus.out_rej, bus.out_x, bus.out_p, bus.out_k); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_init();
    test_interleave();
    test_bad_channel();
    test_bad_denominator();
    test_reset_mid_op();
    test_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
